// File: rtl/memory_responder.sv
// Dual-port (instruction/data) responder in front of a single-ported word RAM.
// One pending slot per port, round-robin grant, fixed access latency, one-cycle ready pulse.
module memory_responder #(
   parameter int unsigned mem_depth   = 65536,
   parameter logic [31:0] mem_base    = 32'h0,
   parameter int unsigned mem_latency = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        imemory_valid,
   input  logic        imemory_instr,
   input  logic [31:0] imemory_addr,
   input  logic [31:0] imemory_wdata,
   input  logic [3:0]  imemory_wstrb,
   output logic [31:0] imemory_rdata,
   output logic        imemory_ready,
   input  logic        dmemory_valid,
   input  logic        dmemory_instr,
   input  logic [31:0] dmemory_addr,
   input  logic [31:0] dmemory_wdata,
   input  logic [3:0]  dmemory_wstrb,
   output logic [31:0] dmemory_rdata,
   output logic        dmemory_ready
);

   localparam int unsigned AW   = $clog2(mem_depth);
   localparam int unsigned CW   = 4;
   localparam int unsigned NP   = 2;
   localparam logic [32:0] SPAN = 33'(mem_depth) << 2;
   localparam logic [CW-1:0] LOAD = CW'(mem_latency - 1);

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               port_q, port_d;
   logic               last_q, last_d;
   req_t               cur_q, cur_d;
   logic [NP-1:0]      pend_vld_q, pend_vld_d;
   req_t [NP-1:0]      pend_q, pend_d;
   logic [NP-1:0]      ready_q, ready_d;
   logic [NP-1:0][31:0] rdata_q, rdata_d;

   logic [31:0]        mem_q [mem_depth];

   req_t [NP-1:0]      live_c, src_c;
   logic [NP-1:0]      valid_c, busy_c, accept_c, elig_c;
   logic               done_c, free_c, grant_c, gport_c;
   logic [31:0]        offset_c, rd_word_c, rd_val_c;
   logic               in_range_c, fire_c, wr_en_c;
   logic [AW-1:0]      idx_c;
   logic               unused_c;

   assign unused_c = imemory_instr ^ dmemory_instr;

   // Per-port request decode: index 0 is the instruction port, 1 the data port
   always_comb begin
      live_c[0] = {imemory_addr, imemory_wdata, imemory_wstrb};
      live_c[1] = {dmemory_addr, dmemory_wdata, dmemory_wstrb};
      valid_c   = {dmemory_valid, imemory_valid};
      for (int p = 0; p < NP; p++) begin
         busy_c[p]   = pend_vld_q[p] |
                       ((state_q == S_ACCESS) && (port_q == 1'(p)) && (cnt_q != '0));
         accept_c[p] = valid_c[p] & ~busy_c[p];
         elig_c[p]   = pend_vld_q[p] | accept_c[p];
         src_c[p]    = pend_vld_q[p] ? pend_q[p] : live_c[p];
      end
   end

   // Engine next state, arbitration and pending-slot bookkeeping
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      port_d     = port_q;
      last_d     = last_q;
      cur_d      = cur_q;
      pend_vld_d = pend_vld_q;
      pend_d     = pend_q;

      done_c  = (state_q == S_ACCESS) && (cnt_q == '0);
      free_c  = (state_q == S_IDLE) || done_c;
      gport_c = (&elig_c) ? ~last_q : elig_c[1];
      grant_c = free_c && (|elig_c);

      for (int p = 0; p < NP; p++) begin
         if (accept_c[p]) begin
            pend_vld_d[p] = 1'b1;
            pend_d[p]     = live_c[p];
         end
      end

      if (grant_c) begin
         pend_vld_d[gport_c] = 1'b0;
         state_d             = S_ACCESS;
         cnt_d               = LOAD;
         port_d              = gport_c;
         cur_d               = src_c[gport_c];
         // Pointer only moves on a real conflict, so a lone requester never steals the next tie
         if (&elig_c) begin
            last_d = gport_c;
         end
      end else if (state_q == S_ACCESS) begin
         if (done_c) begin
            state_d = S_IDLE;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end
   end

   // The access fires on the edge that enters the completion cycle
   assign offset_c   = cur_d.addr - mem_base;
   assign in_range_c = {1'b0, offset_c} < SPAN;
   assign idx_c      = offset_c[AW+1:2];
   assign fire_c     = (state_d == S_ACCESS) && (cnt_d == '0) && !reset;
   assign wr_en_c    = fire_c && in_range_c && (cur_d.wstrb != '0);
   assign rd_word_c  = mem_q[idx_c];

   always_comb begin
      rd_val_c = '0;
      if (in_range_c && (cur_d.wstrb == '0)) begin
         rd_val_c = rd_word_c;
      end
      ready_d = '0;
      rdata_d = '0;
      if (fire_c) begin
         ready_d[port_d] = 1'b1;
         rdata_d[port_d] = rd_val_c;
      end
   end

   // RAM array keeps its contents across reset; all lanes of a write land on one edge
   always_ff @(posedge clock) begin
      if (wr_en_c) begin
         for (int b = 0; b < 4; b++) begin
            if (cur_d.wstrb[b]) begin
               mem_q[idx_c][8*b +: 8] <= cur_d.wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         port_q     <= 1'b0;
         last_q     <= 1'b0;
         cur_q      <= '0;
         pend_vld_q <= '0;
         pend_q     <= '0;
         ready_q    <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         port_q     <= port_d;
         last_q     <= last_d;
         cur_q      <= cur_d;
         pend_vld_q <= pend_vld_d;
         pend_q     <= pend_d;
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
      end
   end

   assign imemory_ready = ready_q[0];
   assign dmemory_ready = ready_q[1];
   assign imemory_rdata = rdata_q[0];
   assign dmemory_rdata = rdata_q[1];

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: four instances cover latency 1/3/4 and an offset base.
module tb_memory_responder;

   localparam int unsigned NI = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst  [NI];
   logic        iv   [NI];
   logic        dv   [NI];
   logic [31:0] ia   [NI];
   logic [31:0] iw   [NI];
   logic [31:0] da   [NI];
   logic [31:0] dw   [NI];
   logic [3:0]  istb [NI];
   logic [3:0]  dstb [NI];
   logic [31:0] ird  [NI];
   logic [31:0] drd  [NI];
   logic        irdy [NI];
   logic        drdy [NI];

   int nvec = 0;
   int nerr = 0;

   memory_responder #(.mem_latency(1)) u_a (
      .clock(clk), .reset(rst[0]),
      .imemory_valid(iv[0]), .imemory_instr(1'b1), .imemory_addr(ia[0]), .imemory_wdata(iw[0]),
      .imemory_wstrb(istb[0]), .imemory_rdata(ird[0]), .imemory_ready(irdy[0]),
      .dmemory_valid(dv[0]), .dmemory_instr(1'b0), .dmemory_addr(da[0]), .dmemory_wdata(dw[0]),
      .dmemory_wstrb(dstb[0]), .dmemory_rdata(drd[0]), .dmemory_ready(drdy[0]));

   memory_responder #(.mem_depth(1024), .mem_latency(3)) u_b (
      .clock(clk), .reset(rst[1]),
      .imemory_valid(iv[1]), .imemory_instr(1'b1), .imemory_addr(ia[1]), .imemory_wdata(iw[1]),
      .imemory_wstrb(istb[1]), .imemory_rdata(ird[1]), .imemory_ready(irdy[1]),
      .dmemory_valid(dv[1]), .dmemory_instr(1'b0), .dmemory_addr(da[1]), .dmemory_wdata(dw[1]),
      .dmemory_wstrb(dstb[1]), .dmemory_rdata(drd[1]), .dmemory_ready(drdy[1]));

   memory_responder #(.mem_depth(1024), .mem_latency(4)) u_c (
      .clock(clk), .reset(rst[2]),
      .imemory_valid(iv[2]), .imemory_instr(1'b1), .imemory_addr(ia[2]), .imemory_wdata(iw[2]),
      .imemory_wstrb(istb[2]), .imemory_rdata(ird[2]), .imemory_ready(irdy[2]),
      .dmemory_valid(dv[2]), .dmemory_instr(1'b0), .dmemory_addr(da[2]), .dmemory_wdata(dw[2]),
      .dmemory_wstrb(dstb[2]), .dmemory_rdata(drd[2]), .dmemory_ready(drdy[2]));

   memory_responder #(.mem_depth(1024), .mem_base(32'h8000_0000), .mem_latency(1)) u_d (
      .clock(clk), .reset(rst[3]),
      .imemory_valid(iv[3]), .imemory_instr(1'b1), .imemory_addr(ia[3]), .imemory_wdata(iw[3]),
      .imemory_wstrb(istb[3]), .imemory_rdata(ird[3]), .imemory_ready(irdy[3]),
      .dmemory_valid(dv[3]), .dmemory_instr(1'b0), .dmemory_addr(da[3]), .dmemory_wdata(dw[3]),
      .dmemory_wstrb(dstb[3]), .dmemory_rdata(drd[3]), .dmemory_ready(drdy[3]));

   typedef struct {
      int          k;
      bit          p;
      logic [31:0] a;
      logic [31:0] w;
      logic [3:0]  s;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t tab [22];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input int k, input bit p, input logic v, input logic [31:0] a,
                        input logic [31:0] w, input logic [3:0] s);
      if (p) begin
         dv[k] = v; da[k] = a; dw[k] = w; dstb[k] = s;
      end else begin
         iv[k] = v; ia[k] = a; iw[k] = w; istb[k] = s;
      end
   endtask

   function automatic logic rdy(input int k, input bit p);
      return p ? drdy[k] : irdy[k];
   endfunction

   function automatic logic [31:0] rdat(input int k, input bit p);
      return p ? drd[k] : ird[k];
   endfunction

   // Single request, valid for one cycle; lat counts cycles until ready (bounded)
   task automatic req(input int k, input bit p, input logic [31:0] a, input logic [31:0] w,
                      input logic [3:0] s, output logic [31:0] rd, output int lat);
      drive(k, p, 1'b1, a, w, s);
      step();
      drive(k, p, 1'b0, '0, '0, '0);
      lat = 1;
      while (!rdy(k, p) && lat < 20) begin
         step();
         lat++;
      end
      rd = rdat(k, p);
   endtask

   // Both ports of instance 1 present reads in the same cycle
   task automatic contend(input bit hold_d, input int exp_i, input int exp_d,
                          input logic [31:0] ai, input logic [31:0] ad,
                          input logic [31:0] exp_ri, input logic [31:0] exp_rd);
      int ti = -1, td = -1, ni = 0, nd = 0;
      logic [31:0] ri = '0, rdd = '0;
      drive(1, 1'b0, 1'b1, ai, '0, '0);
      drive(1, 1'b1, 1'b1, ad, '0, '0);
      for (int c = 1; c <= 12; c++) begin
         step();
         if (irdy[1]) begin ni++; ti = c; ri = ird[1]; end
         if (drdy[1]) begin nd++; td = c; rdd = drd[1]; end
         if (c == 1) drive(1, 1'b0, 1'b0, '0, '0, '0);
         if ((!hold_d && c == 1) || c == 5) drive(1, 1'b1, 1'b0, '0, '0, '0);
      end
      check("contend_i_cycle", 32'(ti), 32'(exp_i));
      check("contend_d_cycle", 32'(td), 32'(exp_d));
      check("contend_i_count", 32'(ni), 32'd1);
      check("contend_d_count", 32'(nd), 32'd1);
      check("contend_i_rdata", ri, exp_ri);
      check("contend_d_rdata", rdd, exp_rd);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int lat, nr;

      for (int k = 0; k < NI; k++) begin
         rst[k] = 1'b1;
         drive(k, 1'b0, 1'b0, '0, '0, '0);
         drive(k, 1'b1, 1'b0, '0, '0, '0);
      end

      //          k  p     addr           wdata          strb    exp rdata      lat
      tab[0]  = '{0, 1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'hF, 32'h0,         1};
      tab[1]  = '{0, 1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 32'h0,         1};
      tab[2]  = '{0, 1'b1, 32'h0000_0010, 32'h0,         4'h0, 32'hAA22_CC44, 1};
      tab[3]  = '{0, 1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'hAA22_CC44, 1};
      tab[4]  = '{0, 1'b0, 32'h0000_0014, 32'h0102_0304, 4'hF, 32'h0,         1};
      tab[5]  = '{0, 1'b1, 32'h0000_0014, 32'h5566_7788, 4'hA, 32'h0,         1};
      tab[6]  = '{0, 1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'h5502_7704, 1};
      tab[7]  = '{0, 1'b1, 32'h0003_FFFC, 32'hCAFE_F00D, 4'hF, 32'h0,         1};
      tab[8]  = '{0, 1'b0, 32'h0003_FFFC, 32'h0,         4'h0, 32'hCAFE_F00D, 1};
      tab[9]  = '{0, 1'b1, 32'h0004_0000, 32'h0,         4'h0, 32'h0,         1};
      tab[10] = '{1, 1'b1, 32'h0000_0040, 32'h1357_9BDF, 4'hF, 32'h0,         3};
      tab[11] = '{1, 1'b0, 32'h0000_0044, 32'h2468_ACE0, 4'hF, 32'h0,         3};
      tab[12] = '{1, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h1357_9BDF, 3};
      tab[13] = '{2, 1'b1, 32'h0000_0020, 32'h0BEE_F000, 4'hF, 32'h0,         4};
      tab[14] = '{2, 1'b1, 32'h0000_0020, 32'h0,         4'h0, 32'h0BEE_F000, 4};
      tab[15] = '{3, 1'b1, 32'h8000_0FFC, 32'h0BAD_F00D, 4'hF, 32'h0,         1};
      tab[16] = '{3, 1'b0, 32'h8000_0000, 32'h600D_CAFE, 4'hF, 32'h0,         1};
      tab[17] = '{3, 1'b1, 32'h8000_1000, 32'h0,         4'h0, 32'h0,         1};
      tab[18] = '{3, 1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 32'h0,         1};
      tab[19] = '{3, 1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'h0BAD_F00D, 1};
      tab[20] = '{3, 1'b1, 32'h8000_0000, 32'h0,         4'h0, 32'h600D_CAFE, 1};
      tab[21] = '{3, 1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0,         1};

      repeat (2) step();
      for (int k = 0; k < NI; k++) rst[k] = 1'b0;
      step();

      // Preload word 0, then a 3-cycle reset with a read presented throughout
      req(0, 1'b1, 32'h0, 32'hC0FF_EE01, 4'hF, rd, lat);
      check("preload_rdata", rd, 32'h0);
      check("preload_lat", 32'(lat), 32'd1);
      step();
      rst[0] = 1'b1;
      drive(0, 1'b1, 1'b1, 32'h0, '0, '0);
      #1;
      check("reset_outputs", ird[0] | drd[0] | {30'b0, irdy[0], drdy[0]}, 32'h0);
      for (int c = 0; c < 3; c++) begin
         step();
         check("reset_outputs", ird[0] | drd[0] | {30'b0, irdy[0], drdy[0]}, 32'h0);
      end
      drive(0, 1'b1, 1'b0, '0, '0, '0);
      rst[0] = 1'b0;
      step();
      check("post_reset_outputs", ird[0] | drd[0] | {30'b0, irdy[0], drdy[0]}, 32'h0);
      req(0, 1'b1, 32'h0, 32'h0, 4'h0, rd, lat);
      check("reset_keeps_ram", rd, 32'hC0FF_EE01);
      step();

      for (int i = 0; i < 22; i++) begin
         req(tab[i].k, tab[i].p, tab[i].a, tab[i].w, tab[i].s, rd, lat);
         check($sformatf("vec%0d_rdata", i), rd, tab[i].exp);
         check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tab[i].lat));
         step();
         check($sformatf("vec%0d_pulse", i), 32'(rdy(tab[i].k, tab[i].p)), 32'd0);
      end

      // Back-to-back on the instruction port: write pass then read pass
      for (int pass = 0; pass < 2; pass++) begin
         bit wr;
         wr = (pass == 0);
         drive(0, 1'b0, 1'b1, 32'h100, wr ? 32'hA500_0000 : 32'h0, wr ? 4'hF : 4'h0);
         for (int i = 0; i < 8; i++) begin
            step();
            check("b2b_ready", 32'(irdy[0]), 32'd1);
            check("b2b_rdata", ird[0], wr ? 32'h0 : 32'hA500_0000 + 32'(i));
            if (i < 7) begin
               drive(0, 1'b0, 1'b1, 32'h100 + 32'(4 * (i + 1)),
                     wr ? 32'hA500_0000 + 32'(i + 1) : 32'h0, wr ? 4'hF : 4'h0);
            end else begin
               drive(0, 1'b0, 1'b0, '0, '0, '0);
            end
         end
         step();
         check("b2b_drain", 32'(irdy[0]), 32'd0);
      end

      // Both ports held valid at latency 1: one completion per cycle, alternating
      drive(0, 1'b0, 1'b1, 32'h10, '0, '0);
      drive(0, 1'b1, 1'b1, 32'h14, '0, '0);
      for (int c = 1; c <= 6; c++) begin
         step();
         check("alt_ready", {30'b0, irdy[0], drdy[0]}, (c % 2 == 1) ? 32'h1 : 32'h2);
         check("alt_rdata", ird[0] | drd[0], (c % 2 == 1) ? 32'h5502_7704 : 32'hAA22_CC44);
         if (c == 6) begin
            drive(0, 1'b0, 1'b0, '0, '0, '0);
            drive(0, 1'b1, 1'b0, '0, '0, '0);
         end
      end
      step();
      check("alt_tail_ready", {30'b0, irdy[0], drdy[0]}, 32'h1);
      check("alt_tail_rdata", drd[0], 32'h5502_7704);
      step();
      check("alt_idle", {30'b0, irdy[0], drdy[0]}, 32'h0);

      // Contention at latency 3, second round also holds dmem valid while busy
      contend(1'b0, 6, 3, 32'h44, 32'h40, 32'h2468_ACE0, 32'h1357_9BDF);
      contend(1'b1, 3, 6, 32'h40, 32'h44, 32'h1357_9BDF, 32'h2468_ACE0);

      // Reset two cycles into a latency-4 write
      nr = 0;
      drive(2, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF);
      for (int s = 1; s <= 12; s++) begin
         step();
         if (irdy[2] || drdy[2]) nr++;
         if (s == 1) drive(2, 1'b1, 1'b0, '0, '0, '0);
         if (s == 2) rst[2] = 1'b1;
         if (s == 3) rst[2] = 1'b0;
      end
      check("abort_no_ready", 32'(nr), 32'd0);
      req(2, 1'b1, 32'h20, 32'h0, 4'h0, rd, lat);
      check("abort_old_value", rd, 32'h0BEE_F000);
      check("abort_read_lat", 32'(lat), 32'd4);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
